biu_arbiter: RTL

Two-port arbiter that shares the single core-side BIU port of the AHB3-Lite bus interface unit between the instruction-fetch path and the data-memory path. It sits directly upstream of the AHB3-Lite BIU. It grants one requestor at a time, forwards its request, and records the owner and beat count of every accepted strobe in a small in-order queue. Returned data acknowledges, read data and errors are steered back to the correct requestor.

---
 rtl/biu_constants_pkg.sv | 43 ++++
 rtl/biu_arb_queue.sv | 60 ++++++
 rtl/biu_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/biu_constants_pkg.sv
// Shared BIU transfer types plus the arbiter's port ids, queue entry and burst beat-count helper.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } biu_type_t;

    typedef logic [2:0] biu_prot_t;

    localparam logic BIU_ARB_PORT_IBIU = 1'b0;
    localparam logic BIU_ARB_PORT_DBIU = 1'b1;

    typedef struct packed {
        logic       owner;
        logic [4:0] beats_left;
    } biu_arb_qent_t;

    // Beats in a burst minus one; undefined-length INCR is tracked as a single beat.
    function automatic logic [3:0] type2cnt(input biu_type_t t);
        case (t)
            WRAP4, INCR4:   type2cnt = 4'd3;
            WRAP8, INCR8:   type2cnt = 4'd7;
            WRAP16, INCR16: type2cnt = 4'd15;
            default:        type2cnt = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/biu_arb_queue.sv
// In-order queue of {owner, beats_left}: push at tail, decrement/auto-pop or flush at head.
// Latency: head/tail/full/empty are registered state; pushes are dropped when full.
module biu_arb_queue
    import biu_constants_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          push_i,
    input  biu_arb_qent_t push_dat_i,
    input  logic          dec_i,
    input  logic          flush_i,
    output biu_arb_qent_t head_o,
    output biu_arb_qent_t tail_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = $clog2(DEPTH);

    biu_arb_qent_t mem [DEPTH];
    logic [PW-1:0] rd_q, wr_q, tail_idx;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop, do_dec, last_beat;

    assign full_o    = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign tail_idx  = wr_q - 1'b1;
    assign head_o    = mem[rd_q];
    assign tail_o    = mem[tail_idx];
    assign last_beat = (head_o.beats_left == 5'd1);

    // An error flush wins over a decrement arriving in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = ~empty_o & (flush_i | (dec_i & last_beat));
    assign do_dec  = ~empty_o & dec_i & ~flush_i & ~last_beat;

    always_ff @(posedge HCLK) begin
        if (do_push) mem[wr_q] <= push_dat_i;
        if (do_dec)  mem[rd_q].beats_left <= head_o.beats_left - 5'd1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/biu_arbiter.sv
// Shares one BIU port between ibiu and dbiu; round-robin, or dbiu priority with BIU_ARB_DPRIO_EN.
// Latency: request path combinational; grant switch the cycle after evaluation. Stb held off when owner queue is full.
module biu_arbiter
    import biu_constants_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = DATA_SIZE,
    parameter int QDEPTH    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,

    input  logic                 ibiu_stb_i,
    output logic                 ibiu_stb_ack_o,
    output logic                 ibiu_d_ack_o,
    input  logic [ADDR_SIZE-1:0] ibiu_adri_i,
    output logic [ADDR_SIZE-1:0] ibiu_adro_o,
    input  biu_size_t            ibiu_size_i,
    input  biu_type_t            ibiu_type_i,
    input  biu_prot_t            ibiu_prot_i,
    input  logic                 ibiu_lock_i,
    input  logic                 ibiu_we_i,
    input  logic [DATA_SIZE-1:0] ibiu_d_i,
    output logic [DATA_SIZE-1:0] ibiu_q_o,
    output logic                 ibiu_ack_o,
    output logic                 ibiu_err_o,

    input  logic                 dbiu_stb_i,
    output logic                 dbiu_stb_ack_o,
    output logic                 dbiu_d_ack_o,
    input  logic [ADDR_SIZE-1:0] dbiu_adri_i,
    output logic [ADDR_SIZE-1:0] dbiu_adro_o,
    input  biu_size_t            dbiu_size_i,
    input  biu_type_t            dbiu_type_i,
    input  biu_prot_t            dbiu_prot_i,
    input  logic                 dbiu_lock_i,
    input  logic                 dbiu_we_i,
    input  logic [DATA_SIZE-1:0] dbiu_d_i,
    output logic [DATA_SIZE-1:0] dbiu_q_o,
    output logic                 dbiu_ack_o,
    output logic                 dbiu_err_o,

    output logic                 biu_stb_o,
    input  logic                 biu_stb_ack_i,
    input  logic                 biu_d_ack_i,
    output logic [ADDR_SIZE-1:0] biu_adri_o,
    input  logic [ADDR_SIZE-1:0] biu_adro_i,
    output biu_size_t            biu_size_o,
    output biu_type_t            biu_type_o,
    output biu_prot_t            biu_prot_o,
    output logic                 biu_lock_o,
    output logic                 biu_we_o,
    output logic [DATA_SIZE-1:0] biu_d_o,
    input  logic [DATA_SIZE-1:0] biu_q_i,
    input  logic                 biu_ack_i,
    input  logic                 biu_err_i
);

    logic          sel_q, sel_d, last_q, last_d;
    logic          sel_stb, sel_lock, eval;
    logic          q_full, q_empty, q_unused;
    biu_arb_qent_t q_head, q_tail, push_ent;

    assign sel_stb  = sel_q ? dbiu_stb_i  : ibiu_stb_i;
    assign sel_lock = sel_q ? dbiu_lock_i : ibiu_lock_i;

    assign biu_stb_o  = sel_stb & ~q_full;
    assign biu_adri_o = sel_q ? dbiu_adri_i : ibiu_adri_i;
    assign biu_size_o = sel_q ? dbiu_size_i : ibiu_size_i;
    assign biu_type_o = sel_q ? dbiu_type_i : ibiu_type_i;
    assign biu_prot_o = sel_q ? dbiu_prot_i : ibiu_prot_i;
    assign biu_lock_o = sel_lock;
    assign biu_we_o   = sel_q ? dbiu_we_i   : ibiu_we_i;
    assign biu_d_o    = sel_q ? dbiu_d_i    : ibiu_d_i;

    assign ibiu_stb_ack_o = biu_stb_ack_i & (sel_q == BIU_ARB_PORT_IBIU);
    assign dbiu_stb_ack_o = biu_stb_ack_i & (sel_q == BIU_ARB_PORT_DBIU);
    assign ibiu_d_ack_o   = biu_d_ack_i & ~q_empty & (q_tail.owner == BIU_ARB_PORT_IBIU);
    assign dbiu_d_ack_o   = biu_d_ack_i & ~q_empty & (q_tail.owner == BIU_ARB_PORT_DBIU);
    assign ibiu_ack_o     = biu_ack_i & ~q_empty & (q_head.owner == BIU_ARB_PORT_IBIU);
    assign dbiu_ack_o     = biu_ack_i & ~q_empty & (q_head.owner == BIU_ARB_PORT_DBIU);
    assign ibiu_err_o     = biu_err_i & ~q_empty & (q_head.owner == BIU_ARB_PORT_IBIU);
    assign dbiu_err_o     = biu_err_i & ~q_empty & (q_head.owner == BIU_ARB_PORT_DBIU);
    assign ibiu_q_o       = biu_q_i;
    assign dbiu_q_o       = biu_q_i;
    assign ibiu_adro_o    = biu_adro_i;
    assign dbiu_adro_o    = biu_adro_i;

    assign push_ent.owner      = sel_q;
    assign push_ent.beats_left = {1'b0, type2cnt(biu_type_o)} + 5'd1;
    assign q_unused            = ^{q_head.beats_left, q_tail.beats_left};

    // A strobe accepted this cycle counts as the most recent grant for the tie-break.
    assign eval = (~sel_stb | biu_stb_ack_i) & ~sel_lock;

    always_comb begin
        sel_d  = sel_q;
        last_d = biu_stb_ack_i ? sel_q : last_q;
        if (eval) begin
            if (ibiu_stb_i && dbiu_stb_i) begin
`ifdef BIU_ARB_DPRIO_EN
                sel_d = BIU_ARB_PORT_DBIU;
`else
                sel_d = ~last_d;
`endif
            end else if (dbiu_stb_i) begin
                sel_d = BIU_ARB_PORT_DBIU;
            end else if (ibiu_stb_i) begin
                sel_d = BIU_ARB_PORT_IBIU;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q  <= BIU_ARB_PORT_DBIU;
            last_q <= BIU_ARB_PORT_DBIU;
        end else begin
            sel_q  <= sel_d;
            last_q <= last_d;
        end
    end

    biu_arb_queue #(.DEPTH(QDEPTH)) u_queue (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .push_i     (biu_stb_ack_i),
        .push_dat_i (push_ent),
        .dec_i      (biu_ack_i),
        .flush_i    (biu_err_i),
        .head_o     (q_head),
        .tail_o     (q_tail),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

endmodule
